// File: rtl/tracking_carrier_pd_arbiter.sv
// Shares one arctan phase detector among NUM_CH carrier tracking channels.
// One-entry pending buffer per channel, round-robin grant, one detector transaction in flight.
module tracking_carrier_pd_arbiter #(
  parameter int NUM_CH                   = 4,
  parameter int CORR_OUTPUT_DATA_WIDTH   = 19,
  parameter int CORDIC_OUTPUT_DATA_WIDTH = 13,
  parameter int TIMEOUT_CYCLES           = 64,
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                       iw_Clk_p_g,
  input  logic                                       iw_Rst_h_g,
  input  logic [NUM_CH-1:0]                          iw_Req_Valid_h,
  input  logic [NUM_CH*CORR_OUTPUT_DATA_WIDTH-1:0]   iw_Req_I_P,
  input  logic [NUM_CH*CORR_OUTPUT_DATA_WIDTH-1:0]   iw_Req_Q_P,
  output logic                                       ow_PD_Valid_h,
  output logic [CORR_OUTPUT_DATA_WIDTH-1:0]          ow_PD_I_P,
  output logic [CORR_OUTPUT_DATA_WIDTH-1:0]          ow_PD_Q_P,
  input  logic                                       iw_PD_Rdy_h,
  input  logic [CORDIC_OUTPUT_DATA_WIDTH-1:0]        iw_PD_Phase_Error,
  output logic [NUM_CH-1:0]                          ow_Carr_Error_Rdy_h,
  output logic [NUM_CH*CORDIC_OUTPUT_DATA_WIDTH-1:0] ow_Carr_Phase_Error,
  input  logic                                       iw_Status_Clr_h,
  output logic [NUM_CH-1:0]                          ow_Overrun_h,
  output logic                                       ow_Timeout_h,
  output logic                                       ow_Busy_h,
  output logic [GW-1:0]                              ow_Grant_Ch
);

  localparam int CW = CORR_OUTPUT_DATA_WIDTH;
  localparam int PW = CORDIC_OUTPUT_DATA_WIDTH;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_ch_reg, last_grant_reg;
  logic [TW-1:0]   wait_cnt_reg;
  logic            timeout_reg;
  logic [CW-1:0]   pd_i_reg, pd_q_reg;

  logic [NUM_CH-1:0] pending_w, overrun_w, carr_rdy_w;
  logic [CW-1:0]     buf_i_w [NUM_CH];
  logic [CW-1:0]     buf_q_w [NUM_CH];

  logic            wait_done;
  logic            issue, busy, grant_load, result_load, timeout_hit;
  logic [GW-1:0]   rr_sel, rr_idx;
  logic            rr_found;

  assign wait_done = (wait_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iw_Clk_p_g or posedge iw_Rst_h_g) begin
    if (iw_Rst_h_g) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|pending_w) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (iw_PD_Rdy_h || wait_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    issue       = (state_reg == ISSUE);
    busy        = (state_reg == ISSUE) || (state_reg == WAIT);
    grant_load  = (state_reg == IDLE) && (|pending_w);
    result_load = (state_reg == WAIT) && iw_PD_Rdy_h;
    timeout_hit = (state_reg == WAIT) && !iw_PD_Rdy_h && wait_done;
  end

  // Round-robin search begins one past the last granted channel.
  always_comb begin
    rr_sel   = last_grant_reg;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      rr_idx = GW'((int'(last_grant_reg) + i) % NUM_CH);
      if (!rr_found && pending_w[rr_idx]) begin
        rr_sel   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge iw_Clk_p_g or posedge iw_Rst_h_g) begin
    if (iw_Rst_h_g) begin
      grant_ch_reg   <= '0;
      last_grant_reg <= GW'(NUM_CH - 1);
      wait_cnt_reg   <= '0;
      timeout_reg    <= 1'b0;
      pd_i_reg       <= '0;
      pd_q_reg       <= '0;
    end else begin
      if (grant_load) begin
        grant_ch_reg   <= rr_sel;
        last_grant_reg <= rr_sel;
      end
      wait_cnt_reg <= (state_reg == WAIT) ? wait_cnt_reg + 1'b1 : '0;
      timeout_reg  <= timeout_hit;
      if (issue) begin
        pd_i_reg <= buf_i_w[grant_ch_reg];
        pd_q_reg <= buf_q_w[grant_ch_reg];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic          req_k, issuing_k, result_k;
      logic          pending_reg, overrun_reg, carr_rdy_reg;
      logic [CW-1:0] buf_i_reg, buf_q_reg;
      logic [PW-1:0] phase_reg;

      assign req_k     = iw_Req_Valid_h[gi];
      assign issuing_k = issue && (grant_ch_reg == GW'(gi));
      assign result_k  = result_load && (grant_ch_reg == GW'(gi));

      // A request in this channel's own issue cycle re-arms pending without an overrun.
      always_ff @(posedge iw_Clk_p_g or posedge iw_Rst_h_g) begin
        if (iw_Rst_h_g) begin
          pending_reg  <= 1'b0;
          overrun_reg  <= 1'b0;
          carr_rdy_reg <= 1'b0;
          buf_i_reg    <= '0;
          buf_q_reg    <= '0;
          phase_reg    <= '0;
        end else begin
          if (req_k) begin
            buf_i_reg   <= iw_Req_I_P[gi*CW +: CW];
            buf_q_reg   <= iw_Req_Q_P[gi*CW +: CW];
            pending_reg <= 1'b1;
          end else if (issuing_k) begin
            pending_reg <= 1'b0;
          end
          overrun_reg  <= (overrun_reg && !iw_Status_Clr_h) ||
                          (req_k && pending_reg && !issuing_k);
          carr_rdy_reg <= result_k;
          if (result_k) phase_reg <= iw_PD_Phase_Error;
        end
      end

      assign pending_w[gi]  = pending_reg;
      assign overrun_w[gi]  = overrun_reg;
      assign carr_rdy_w[gi] = carr_rdy_reg;
      assign buf_i_w[gi]    = buf_i_reg;
      assign buf_q_w[gi]    = buf_q_reg;
      assign ow_Carr_Phase_Error[gi*PW +: PW] = phase_reg;
    end
  endgenerate

  // The live buffer is presented during ISSUE and frozen afterwards.
  assign ow_PD_Valid_h       = issue;
  assign ow_PD_I_P           = issue ? buf_i_w[grant_ch_reg] : pd_i_reg;
  assign ow_PD_Q_P           = issue ? buf_q_w[grant_ch_reg] : pd_q_reg;
  assign ow_Carr_Error_Rdy_h = carr_rdy_w;
  assign ow_Overrun_h        = overrun_w;
  assign ow_Timeout_h        = timeout_reg;
  assign ow_Busy_h           = busy;
  assign ow_Grant_Ch         = grant_ch_reg;

endmodule

// File: tb/tb_tracking_carrier_pd_arbiter.sv
// Randomized and directed check of the shared phase-detector arbiter against a
// transaction-level model of pending buffers, round-robin grants and detector results.
module tb_tracking_carrier_pd_arbiter;

  localparam int NCH = 4;
  localparam int CW  = 19;
  localparam int PW  = 13;
  localparam int TO  = 64;
  localparam int GW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NCH-1:0]      req_valid = '0;
  logic [NCH*CW-1:0]   req_i = '0, req_q = '0;
  logic                pd_valid;
  logic [CW-1:0]       pd_i, pd_q;
  logic                pd_rdy = 1'b0;
  logic [PW-1:0]       pd_err = '0;
  logic [NCH-1:0]      carr_rdy;
  logic [NCH*PW-1:0]   carr_err;
  logic                status_clr = 1'b0;
  logic [NCH-1:0]      overrun;
  logic                timeout, busy;
  logic [GW-1:0]       grant;

  tracking_carrier_pd_arbiter #(
    .NUM_CH(NCH), .CORR_OUTPUT_DATA_WIDTH(CW),
    .CORDIC_OUTPUT_DATA_WIDTH(PW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .iw_Clk_p_g(clk), .iw_Rst_h_g(rst),
    .iw_Req_Valid_h(req_valid), .iw_Req_I_P(req_i), .iw_Req_Q_P(req_q),
    .ow_PD_Valid_h(pd_valid), .ow_PD_I_P(pd_i), .ow_PD_Q_P(pd_q),
    .iw_PD_Rdy_h(pd_rdy), .iw_PD_Phase_Error(pd_err),
    .ow_Carr_Error_Rdy_h(carr_rdy), .ow_Carr_Phase_Error(carr_err),
    .iw_Status_Clr_h(status_clr), .ow_Overrun_h(overrun),
    .ow_Timeout_h(timeout), .ow_Busy_h(busy), .ow_Grant_Ch(grant)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [CW-1:0]  m_bi [NCH];
  logic [CW-1:0]  m_bq [NCH];
  logic [PW-1:0]  m_err [NCH];
  logic [NCH-1:0] m_pend, m_ov;
  int             m_last, m_gch, m_wcnt, m_lat;
  bit             m_out, m_grant_flag;

  // Stimulus controls
  logic [CW-1:0]  d_i [NCH];
  logic [CW-1:0]  d_q [NCH];
  logic [PW-1:0]  d_err;
  int             lat_cfg = -1;
  bit             spur_en = 0;
  bit             force_rdy = 0;
  int             to_seen = 0;

  function automatic int rr_pick(input logic [NCH-1:0] p, input int last);
    for (int i = 1; i <= NCH; i++) begin
      if (p[(last + i) % NCH]) return (last + i) % NCH;
    end
    return last;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_bi[k] = '0; m_bq[k] = '0; m_err[k] = '0;
    end
    m_pend = '0; m_ov = '0; m_last = NCH - 1; m_gch = 0;
    m_wcnt = 0; m_lat = 0; m_out = 0; m_grant_flag = 0;
  endtask

  task automatic step(input logic [NCH-1:0] req, input bit clr);
    logic [NCH-1:0] ovs, exp_rdy;
    bit issuing, out_s, gnext, exp_to;
    req_valid = req;
    for (int k = 0; k < NCH; k++) begin
      req_i[k*CW +: CW] = d_i[k];
      req_q[k*CW +: CW] = d_q[k];
    end
    status_clr = clr;
    pd_err = d_err;
    if (force_rdy) pd_rdy = 1'b1;
    else if (m_out) pd_rdy = (m_wcnt == m_lat);
    else pd_rdy = spur_en && ($urandom_range(0, 7) == 0);
    #1;
    issuing = m_grant_flag;
    out_s   = m_out;
    check_val("pd_valid", pd_valid, issuing);
    check_val("busy", busy, issuing || m_out);
    if (issuing) begin
      check_val("grant", grant, m_gch);
      check_val("pd_i", pd_i, m_bi[m_gch]);
      check_val("pd_q", pd_q, m_bq[m_gch]);
      $display("issue ch=%0d i=%0h q=%0h", m_gch, m_bi[m_gch], m_bq[m_gch]);
    end
    exp_rdy = '0; exp_to = 0;
    if (m_out) begin
      if (pd_rdy) begin
        exp_rdy[m_gch] = 1'b1; m_err[m_gch] = d_err; m_out = 0;
      end else if (m_wcnt == TO - 1) begin
        exp_to = 1; m_out = 0; to_seen++;
      end else begin
        m_wcnt++;
      end
    end
    gnext = 0;
    if (!issuing && !out_s && m_pend != 0) begin
      gnext = 1; m_gch = rr_pick(m_pend, m_last);
    end
    ovs = '0;
    for (int k = 0; k < NCH; k++)
      if (req[k] && m_pend[k] && !(issuing && m_gch == k)) ovs[k] = 1'b1;
    if (issuing) begin
      m_pend[m_gch] = 1'b0; m_last = m_gch; m_out = 1; m_wcnt = 0;
      if (lat_cfg >= 0) m_lat = lat_cfg;
      else if ($urandom_range(0, 14) == 0) m_lat = 1000;
      else m_lat = $urandom_range(0, 20);
    end
    for (int k = 0; k < NCH; k++) begin
      if (req[k]) begin
        m_bi[k] = d_i[k]; m_bq[k] = d_q[k]; m_pend[k] = 1'b1;
      end
    end
    m_ov = (clr ? '0 : m_ov) | ovs;
    m_grant_flag = gnext;
    @(posedge clk); #1;
    check_val("carr_rdy", carr_rdy, exp_rdy);
    check_val("timeout", timeout, exp_to);
    check_val("overrun", overrun, m_ov);
    for (int k = 0; k < NCH; k++)
      check_val($sformatf("phase_err%0d", k), carr_err[k*PW +: PW], m_err[k]);
    if (exp_rdy != 0) $display("result rdy=%b err=%0h", exp_rdy, d_err);
    req_valid = '0; status_clr = 1'b0; pd_rdy = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      if (!m_out && m_pend == 0 && !m_grant_flag) done = 1;
      else step('0, 0);
    end
    check_val("drain_idle", (!m_out && m_pend == 0 && !m_grant_flag), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_pdv"}, pd_valid, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_rdy"}, carr_rdy, 0);
    check_val({tag, "_err"}, carr_err, 0);
    check_val({tag, "_ovr"}, overrun, 0);
    check_val({tag, "_to"}, timeout, 0);
    check_val({tag, "_grant"}, grant, 0);
    check_val({tag, "_pdi"}, pd_i, 0);
    check_val({tag, "_pdq"}, pd_q, 0);
  endtask

  logic [31:0] r;

  initial begin
    for (int k = 0; k < NCH; k++) begin d_i[k] = '0; d_q[k] = '0; end
    d_err = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Single channel: 17-cycle detector latency, result 0x0C9
    d_i[0] = 19'd100; d_q[0] = -19'sd50; d_err = 13'h0C9; lat_cfg = 16;
    step(4'b0001, 0);
    drain();
    check_val("ch0_result", carr_err[0 +: PW], 13'h0C9);

    // All channels at once
    for (int k = 0; k < NCH; k++) begin d_i[k] = 19'(k * 1000 + 7); d_q[k] = 19'(k * 333 + 1); end
    step(4'b1111, 0);
    for (int n = 0; n < 200 && (m_out || m_pend != 0 || m_grant_flag); n++) begin
      d_err = PW'(n * 37 + 5);
      step('0, 0);
    end
    drain();

    // Overrun on ch2 while ch1 waits
    lat_cfg = 16;
    d_i[1] = 19'd11; d_q[1] = 19'd12;
    step(4'b0010, 0);
    step('0, 0); step('0, 0);
    d_i[2] = 19'h00AAA; d_q[2] = 19'h00BBB;
    step(4'b0100, 0);
    repeat (4) step('0, 0);
    d_i[2] = 19'h01234; d_q[2] = 19'h05678;
    step(4'b0100, 0);
    check_val("ovr2_set", overrun[2], 1);
    drain();
    step('0, 1);
    check_val("ovr2_clr", overrun[2], 0);

    // Detector silence on ch0, then ch1 served
    lat_cfg = 1000;
    step(4'b0011, 0);
    step('0, 0); step('0, 0);
    lat_cfg = 5;
    drain();
    check_val("timeout_seen", to_seen, 1);

    // Ch3 re-requested in its own issue cycle
    lat_cfg = 8;
    d_i[3] = 19'd300; d_q[3] = 19'd301;
    step(4'b1000, 0);
    step('0, 0);
    d_i[3] = 19'd400; d_q[3] = 19'd401;
    step(4'b1000, 0);
    check_val("ovr3_clear", overrun[3], 0);
    drain();

    // Randomized traffic
    lat_cfg = -1; spur_en = 1;
    for (int n = 0; n < 400; n++) begin
      logic [NCH-1:0] rq;
      for (int k = 0; k < NCH; k++) begin
        r = $urandom(); d_i[k] = r[CW-1:0];
        r = $urandom(); d_q[k] = r[CW-1:0];
        rq[k] = ($urandom_range(0, 5) == 0);
      end
      r = $urandom(); d_err = r[PW-1:0];
      step(rq, $urandom_range(0, 19) == 0);
    end
    spur_en = 0; lat_cfg = 10;
    drain();

    // Reset during WAIT, late detector ready afterwards
    lat_cfg = 1000;
    step(4'b0100, 0);
    repeat (5) step('0, 0);
    #2 rst = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    force_rdy = 1;
    step('0, 0);
    force_rdy = 0;
    check_val("late_rdy", carr_rdy, 0);
    step('0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
